// File: rtl/store_buffer.sv
// In-order store buffer between the store RS, the ROB commit port and the
// data-memory write port. Stores wait here until committed, then drain
// oldest-first over a req/ack handshake with byte-lane formatting.
// Optional feature: define STORE_FORWARD_EN to build the store-to-load
// forwarding search and the ld_* ports.
module store_buffer #(
  parameter int unsigned DEPTH       = 4,
  parameter logic [5:0]  INVALID_ROB = 6'b010000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        storeEnable,
  input  logic [31:0] data1_in,
  input  logic [31:0] data2_in,
  input  logic [5:0]  robNum_in,
  input  logic [2:0]  subType_in,
  output logic        full,
  output logic        ack_valid,
  output logic [5:0]  ack_rob,
  input  logic        commitValid,
  input  logic [5:0]  commitRob,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
`ifdef STORE_FORWARD_EN
  ,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  output logic        ld_stall
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e state_q;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] cmt_q, cmt_d, cmt_eff;
  logic [5:0]       rob_q  [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [2:0]       sub_q  [DEPTH];

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d, keep_cnt;

  logic        push, pop;
  logic [31:0] hd_addr, hd_data;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;

  // full comes from the registered count only, so a same-cycle pop never frees a slot
  assign full = (count_q == CntW'(DEPTH));
  assign push = storeEnable && !full && !flush;
  assign pop  = (state_q == StWait) && mem_ack;

  // Commit flags including this cycle's commit, so a flush in the same cycle keeps it
  always_comb begin
    cmt_eff = cmt_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (commitValid && valid_q[i] && (rob_q[i] == commitRob)) cmt_eff[i] = 1'b1;
    end
  end

  // Number of entries that survive a flush (committed prefix, including in-flight head)
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && cmt_eff[i]) keep_cnt = keep_cnt + CntW'(1);
    end
  end

  // Next-state for valid/commit flags and the head/tail/count bookkeeping
  always_comb begin
    valid_d = valid_q;
    cmt_d   = cmt_eff;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      cmt_d[head_q]   = 1'b0;
      head_d          = head_q + PtrW'(1);
    end
    if (flush) begin
      valid_d = valid_d & cmt_eff;
      cmt_d   = cmt_d & valid_d;
      // Survivors start at the old head, so the new tail sits just past them
      tail_d  = head_q + keep_cnt[PtrW-1:0];
      count_d = pop ? (keep_cnt - CntW'(1)) : keep_cnt;
    end else begin
      if (push) begin
        valid_d[tail_q] = 1'b1;
        cmt_d[tail_q]   = 1'b0;
        tail_d          = tail_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Buffer state, entry payload and the push acknowledge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q   <= '0;
      cmt_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ack_valid <= 1'b0;
      ack_rob   <= INVALID_ROB;
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i]  <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
        sub_q[i]  <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      cmt_q     <= cmt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ack_valid <= push;
      ack_rob   <= push ? robNum_in : INVALID_ROB;
      if (push) begin
        rob_q[tail_q]  <= robNum_in;
        addr_q[tail_q] <= data2_in;
        data_q[tail_q] <= data1_in;
        sub_q[tail_q]  <= subType_in;
      end
    end
  end

  // Byte-lane formatting of the head entry
  always_comb begin
    hd_addr    = addr_q[head_q];
    hd_data    = data_q[head_q];
    lane_be    = 4'b0000;
    lane_wdata = hd_data;
    case (sub_q[head_q])
      3'b000: begin
        lane_be    = 4'b0001 << hd_addr[1:0];
        lane_wdata = {4{hd_data[7:0]}};
      end
      3'b001: begin
        lane_be    = hd_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{hd_data[15:0]}};
      end
      3'b010: begin
        lane_be    = 4'b1111;
        lane_wdata = hd_data;
      end
      // Unknown sizes drain with no lanes enabled
      default: begin
        lane_be    = 4'b0000;
        lane_wdata = hd_data;
      end
    endcase
  end

  // Drain FSM: launch a committed head, hold mem_* until the memory acks
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (valid_q[head_q] && cmt_q[head_q]) begin
            mem_addr  <= {hd_addr[31:2], 2'b00};
            mem_wdata <= lane_wdata;
            mem_be    <= lane_be;
            mem_req   <= 1'b1;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef STORE_FORWARD_EN
  logic [PtrW-1:0] fwd_idx;
  logic            unused_ld;
  assign unused_ld = ^ld_addr[1:0];

  // Walk oldest to youngest so the last word match (youngest) decides the result
  always_comb begin
    ld_hit   = 1'b0;
    ld_stall = 1'b0;
    ld_data  = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PtrW'(k);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx][31:2] == ld_addr[31:2])) begin
        if (sub_q[fwd_idx] == 3'b010) begin
          ld_hit   = 1'b1;
          ld_stall = 1'b0;
          ld_data  = data_q[fwd_idx];
        end else begin
          ld_hit   = 1'b0;
          ld_stall = 1'b1;
          ld_data  = '0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: table-driven lane vectors, directed
// multi-cycle sequences, and a randomized run against a queue-based model.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [5:0]  INV   = 6'b010000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        storeEnable, commitValid, flush, mem_ack;
  logic [31:0] data1_in, data2_in;
  logic [5:0]  robNum_in, commitRob;
  logic [2:0]  subType_in;
  logic        full, ack_valid, mem_req;
  logic [5:0]  ack_rob;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
`ifdef STORE_FORWARD_EN
  logic [31:0] ld_addr, ld_data;
  logic        ld_hit, ld_stall;
`endif

  always #5 clock = ~clock;

  store_buffer #(.DEPTH(DEPTH), .INVALID_ROB(INV)) dut (
    .clock(clock), .reset(reset), .storeEnable(storeEnable),
    .data1_in(data1_in), .data2_in(data2_in), .robNum_in(robNum_in),
    .subType_in(subType_in), .full(full), .ack_valid(ack_valid), .ack_rob(ack_rob),
    .commitValid(commitValid), .commitRob(commitRob), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack)
`ifdef STORE_FORWARD_EN
    , .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall)
`endif
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  sub;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [5:0]  rob;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  sub;
    bit          cmt;
  } ent_t;

  vec_t        vecs[6];
  ent_t        q[$];
  ent_t        keep[$];
  bit          hs, full_pre, acc, drain, seen, ok;
  int          ui;
  logic [5:0]  rob_ctr;
  logic [31:0] ea, ew;
  logic [3:0]  eb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Expected memory-side view of a store, from the lane rules
  function automatic void lanes(input logic [2:0] sub, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] o_addr, output logic [3:0] o_be,
                                output logic [31:0] o_wd);
    o_addr = a & 32'hFFFF_FFFC;
    o_be   = 4'h0;
    o_wd   = d;
    if (sub == 3'd0) begin
      o_be = 4'(1 << a[1:0]);
      o_wd = 32'(d[7:0]) * 32'h0101_0101;
    end else if (sub == 3'd1) begin
      o_be = a[1] ? 4'hC : 4'h3;
      o_wd = 32'(d[15:0]) * 32'h0001_0001;
    end else if (sub == 3'd2) begin
      o_be = 4'hF;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [2:0] sub, input logic [31:0] a, input logic [31:0] d,
                      input logic [5:0] rob);
    storeEnable = 1'b1; subType_in = sub; data2_in = a; data1_in = d; robNum_in = rob;
    tick();
    storeEnable = 1'b0;
  endtask

  task automatic commit(input logic [5:0] rob);
    commitValid = 1'b1; commitRob = rob;
    tick();
    commitValid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) tick();
    check(name, mem_req, 1);
  endtask

  task automatic ack_mem();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic quiet(input int n, input string name);
    seen = 1'b0;
    repeat (n) begin
      if (mem_req === 1'b1) seen = 1'b1;
      tick();
    end
    check(name, seen, 0);
  endtask

  task automatic clean_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    storeEnable = 0; commitValid = 0; flush = 0; mem_ack = 0;
    data1_in = 0; data2_in = 0; robNum_in = 0; commitRob = 0; subType_in = 0;
`ifdef STORE_FORWARD_EN
    ld_addr = 0;
`endif
    vecs[0] = '{3'd0, 32'h0000_0203, 32'h1234_56AB, 32'h0000_0200, 4'b1000, 32'hABAB_ABAB};
    vecs[1] = '{3'd1, 32'h0000_0202, 32'h0000_1234, 32'h0000_0200, 4'b1100, 32'h1234_1234};
    vecs[2] = '{3'd1, 32'h0000_0201, 32'hFFFF_BEEF, 32'h0000_0200, 4'b0011, 32'hBEEF_BEEF};
    vecs[3] = '{3'd2, 32'h0000_07FC, 32'h0102_0304, 32'h0000_07FC, 4'b1111, 32'h0102_0304};
    vecs[4] = '{3'd0, 32'h0000_0100, 32'h0000_005A, 32'h0000_0100, 4'b0001, 32'h5A5A_5A5A};
    vecs[5] = '{3'd7, 32'h0000_0043, 32'h0000_0099, 32'h0000_0040, 4'b0000, 32'h0000_0000};

    // Reset state
    repeat (2) tick();
    check("rst_full", full, 0);
    check("rst_ack_valid", ack_valid, 0);
    check("rst_ack_rob", ack_rob, INV);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be", mem_be, 0);
    reset = 1'b1;
    tick();

    // Single SW through the whole path
    push(3'd2, 32'h104, 32'hDEAD_BEEF, 6'd3);
    check("t1_ack_valid", ack_valid, 1);
    check("t1_ack_rob", ack_rob, 3);
    check("t1_no_req", mem_req, 0);
    tick();
    check("t1_ack_pulse", ack_valid, 0);
    check("t1_ack_rob_idle", ack_rob, INV);
    check("t1_uncommitted_no_req", mem_req, 0);
    commit(6'd3);
    wait_req("t1_req");
    check("t1_addr", mem_addr, 32'h104);
    check("t1_be", mem_be, 4'hF);
    check("t1_wdata", mem_wdata, 32'hDEAD_BEEF);
    ack_mem();
    check("t1_req_drop", mem_req, 0);
    quiet(5, "t1_empty");

    // Lane table
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].sub, vecs[i].addr, vecs[i].data, 6'(40 + i));
      commit(6'(40 + i));
      wait_req($sformatf("vec%0d_req", i));
      check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_be", i), mem_be, vecs[i].exp_be);
      if (vecs[i].exp_be != 4'h0) check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
      ack_mem();
    end
    quiet(4, "vec_empty");

    // Full, dropped push, drain frees a slot
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t3_not_full_before_%0d", i), full, 0);
      push(3'd2, 32'h800 + 32'(4 * i), 32'(i), 6'(i));
    end
    check("t3_full", full, 1);
    push(3'd2, 32'h900, 32'h5, 6'd5);
    check("t3_drop_no_ack", ack_valid, 0);
    check("t3_still_full", full, 1);
    commit(6'd1);
    wait_req("t3_req");
    check("t3_addr", mem_addr, 32'h804);
    ack_mem();
    check("t3_not_full", full, 0);
    do_flush();
    quiet(10, "t3_flushed");

    // Commit+flush+push in one cycle; only rob 1 survives
    push(3'd2, 32'h900, 32'hA1, 6'd1);
    push(3'd2, 32'h904, 32'hA2, 6'd2);
    push(3'd2, 32'h908, 32'hA3, 6'd3);
    commitValid = 1'b1; commitRob = 6'd1; flush = 1'b1;
    storeEnable = 1'b1; robNum_in = 6'd9; data2_in = 32'h90C; subType_in = 3'd2;
    tick();
    commitValid = 1'b0; flush = 1'b0; storeEnable = 1'b0;
    check("t4_flush_push_no_ack", ack_valid, 0);
    push(3'd2, 32'hA00, 32'h0, 6'd10);
    push(3'd2, 32'hA04, 32'h0, 6'd11);
    check("t4_count3_not_full", full, 0);
    push(3'd2, 32'hA08, 32'h0, 6'd12);
    check("t4_count4_full", full, 1);
    wait_req("t4_req");
    check("t4_addr", mem_addr, 32'h900);
    check("t4_wdata", mem_wdata, 32'hA1);
    ack_mem();
    do_flush();
    quiet(10, "t4_no_more_writes");

    // Slow memory: outputs hold while waiting
    push(3'd2, 32'h500, 32'hCAFE_F00D, 6'd20);
    commit(6'd20);
    wait_req("t5_req");
    ok = 1'b1;
    repeat (5) begin
      tick();
      if (mem_req !== 1'b1 || mem_addr !== 32'h500 || mem_be !== 4'hF ||
          mem_wdata !== 32'hCAFE_F00D) ok = 1'b0;
    end
    check("t5_stable", ok, 1);
    ack_mem();
    check("t5_req_drop", mem_req, 0);
    push(3'd0, 32'h601, 32'h77, 6'd21);
    commit(6'd21);
    wait_req("t5_req2");
    #2 reset = 1'b0;
    #1 check("t5_async_req", mem_req, 0);
    check("t5_async_full", full, 0);
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) push(3'd2, 32'hB00, 32'h0, 6'(50 + i));
    check("t5_count_cleared", full, 0);
    push(3'd2, 32'hB00, 32'h0, 6'd53);
    check("t5_refill_full", full, 1);
    clean_reset();

`ifdef STORE_FORWARD_EN
    // Forwarding: youngest SW wins, a younger narrow store forces a stall
    push(3'd2, 32'h300, 32'h1122_3344, 6'd30);
    push(3'd2, 32'h300, 32'h5566_7788, 6'd31);
    ld_addr = 32'h300;
    #1;
    check("t6_hit", ld_hit, 1);
    check("t6_data", ld_data, 32'h5566_7788);
    check("t6_no_stall", ld_stall, 0);
    push(3'd0, 32'h301, 32'hEE, 6'd32);
    check("t6_stall", ld_stall, 1);
    check("t6_stall_no_hit", ld_hit, 0);
    ld_addr = 32'h400;
    #1;
    check("t6_miss_hit", ld_hit, 0);
    check("t6_miss_stall", ld_stall, 0);
    clean_reset();
`endif

    // Randomized run against the queue model
    q.delete();
    rob_ctr = 6'd0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      drain = (cyc >= 600);
      storeEnable = !drain && ($urandom_range(0, 9) < 4);
      subType_in = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      data2_in = 32'h600 | 32'($urandom_range(0, 15));
      data1_in = $urandom;
      robNum_in = rob_ctr;
      rob_ctr = (rob_ctr >= 6'd47) ? 6'd0 : rob_ctr + 6'd1;
      if (rob_ctr == INV) rob_ctr = rob_ctr + 6'd1;
      ui = -1;
      for (int k = q.size() - 1; k >= 0; k--) if (!q[k].cmt) ui = k;
      commitValid = 1'b0;
      if (ui >= 0 && (drain || $urandom_range(0, 2) == 0)) begin
        commitValid = 1'b1; commitRob = q[ui].rob;
      end else if ($urandom_range(0, 19) == 0) begin
        commitValid = 1'b1; commitRob = 6'd63;
      end
      flush = !drain && ($urandom_range(0, 24) == 0);
      mem_ack = drain || ($urandom_range(0, 2) == 0);
`ifdef STORE_FORWARD_EN
      ld_addr = 32'h600 | 32'($urandom_range(0, 15));
`endif
      #1;
`ifdef STORE_FORWARD_EN
      begin
        logic e_hit, e_stall;
        logic [31:0] e_data;
        e_hit = 0; e_stall = 0; e_data = 0;
        foreach (q[k]) if (q[k].addr[31:2] == ld_addr[31:2]) begin
          e_hit = (q[k].sub == 3'd2); e_stall = !e_hit; e_data = q[k].data;
        end
        check("rand_ld_hit", ld_hit, e_hit);
        check("rand_ld_stall", ld_stall, e_stall);
        if (e_hit) check("rand_ld_data", ld_data, e_data);
      end
`endif
      if (mem_req === 1'b1) begin
        if (q.size() == 0) check("rand_req_with_empty_model", 0, 1);
        else begin
          lanes(q[0].sub, q[0].addr, q[0].data, ea, eb, ew);
          check("rand_req_committed", q[0].cmt, 1);
          check("rand_mem_addr", mem_addr, ea);
          check("rand_mem_be", mem_be, eb);
          if (eb != 4'h0) check("rand_mem_wdata", mem_wdata, ew);
        end
      end
      hs = (mem_req === 1'b1) && mem_ack;
      full_pre = (q.size() == DEPTH);
      tick();
      if (commitValid) foreach (q[k]) if (q[k].rob == commitRob) q[k].cmt = 1'b1;
      if (hs && q.size() > 0) void'(q.pop_front());
      if (flush) begin
        keep.delete();
        foreach (q[k]) if (q[k].cmt) keep.push_back(q[k]);
        q = keep;
      end
      acc = storeEnable && !flush && !full_pre;
      if (acc) q.push_back('{robNum_in, data2_in, data1_in, subType_in, 1'b0});
      check("rand_ack_valid", ack_valid, acc);
      check("rand_ack_rob", ack_rob, acc ? robNum_in : INV);
      check("rand_full", full, q.size() == DEPTH);
    end
    storeEnable = 0; commitValid = 0; flush = 0; mem_ack = 0;
    check("rand_model_drained", q.size(), 0);
    check("rand_end_req", mem_req, 0);
    check("rand_end_full", full, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
